// File: rtl/multi_mode_bus_sync_pkg.sv
// rtl/multi_mode_bus_sync_pkg.sv - shared constants for the strobe-qualified bus synchroniser
package multi_mode_bus_sync_pkg;

    localparam int MODE_LEVEL      = 0;
    localparam int MODE_RISE       = 1;
    localparam int MODE_TOGGLE     = 2;
    localparam int MIN_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_ACCEPT  = 2'd1,
        EVT_DROP    = 2'd2,
        EVT_CONSUME = 2'd3
    } evt_action_e;

    function automatic bit is_valid_mode(input int mode);
        return (mode == MODE_LEVEL) || (mode == MODE_RISE) || (mode == MODE_TOGGLE);
    endfunction

endpackage

// File: rtl/multi_mode_bus_sync_sync_chain.sv
// rtl/multi_mode_bus_sync_sync_chain.sv - enable-gated multi-stage flop chain for crossing into clk
module sync_chain
    import multi_mode_bus_sync_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
        $error("sync_chain: STAGES must be at least %0d", MIN_SYNC_STAGES);
    end

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else if (ena) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/multi_mode_bus_sync.sv
// rtl/multi_mode_bus_sync.sv - strobe-qualified bus capture with valid/ready, overflow and event count
module multi_mode_bus_sync
    import multi_mode_bus_sync_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             stb,
    input  logic [N-1:0]     data_in,
    input  logic             out_ready,
    input  logic             ovf_clr,
    output logic [N-1:0]     data_out,
    output logic             out_valid,
    output logic             overflow,
    output logic [CNT_W-1:0] evt_count
);

    if (!is_valid_mode(MODE)) begin : g_bad_mode
        $error("multi_mode_bus_sync: MODE must be 0, 1 or 2");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("multi_mode_bus_sync: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
    end
    if (N < 1) begin : g_bad_width
        $error("multi_mode_bus_sync: N must be at least 1");
    end

    logic             w_s;
    logic             w_evt;
    logic             w_free;
    evt_action_e      w_action;
    logic             r_stb_q;
    logic [N-1:0]     r_data_out;
    logic             r_out_valid;
    logic             r_overflow;
    logic [CNT_W-1:0] r_evt_count;

    sync_chain #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_stb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .i_d   (stb),
        .o_q   (w_s)
    );

    // r_stb_q holds the previous synchronised strobe so edges can be seen
    always_comb begin
        w_evt = 1'b0;
        if (ena) begin
            case (MODE)
                MODE_LEVEL: w_evt = w_s;
                MODE_RISE:  w_evt = w_s & ~r_stb_q;
                default:    w_evt = w_s ^ r_stb_q;
            endcase
        end
    end

    assign w_free = ~r_out_valid | out_ready;

    always_comb begin
        w_action = EVT_NONE;
        if (w_evt && w_free) begin
            w_action = EVT_ACCEPT;
        end else if (w_evt) begin
            w_action = EVT_DROP;
        end else if (ena && r_out_valid && out_ready) begin
            w_action = EVT_CONSUME;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_q     <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_evt_count <= '0;
        end else if (ena) begin
            r_stb_q <= w_s;
            case (w_action)
                EVT_ACCEPT: begin
                    r_data_out  <= data_in;
                    r_out_valid <= 1'b1;
                    r_evt_count <= r_evt_count + CNT_W'(1);
                end
                EVT_CONSUME: r_out_valid <= 1'b0;
                default: ;
            endcase
            // a drop in the same cycle as a clear leaves the flag set
            if (w_action == EVT_DROP) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;
    assign evt_count = r_evt_count;

endmodule

// File: tb/tb_multi_mode_bus_sync.sv
// tb/tb_multi_mode_bus_sync.sv - scoreboard bench running level, rise and toggle instances side by side
module tb_multi_mode_bus_sync;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic       o;
        logic [7:0] c;
    } st_t;
    typedef st_t [2:0] snap_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       stb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       out_ready = 1'b0;
    logic       ovf_clr = 1'b0;

    logic [7:0] dout [3];
    logic       vld  [3];
    logic       ovf  [3];
    logic [7:0] cnt  [3];

    snap_t exp_q [$];
    event  ev_now;
    bit    done = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;

    // reference state, one slot per instance (instance index == MODE)
    logic [7:0]  m_d [3];
    logic        m_v [3];
    logic        m_o [3];
    logic [7:0]  m_c [3];
    logic [15:0] m_hist [3];
    logic        m_prev [3];

    always #5 clk = ~clk;

    multi_mode_bus_sync #(.N(8), .SYNC_STAGES(2), .MODE(0), .CNT_W(8)) u_lvl (
        .clk(clk), .rst_n(rst_n), .ena(ena), .stb(stb), .data_in(data_in),
        .out_ready(out_ready), .ovf_clr(ovf_clr), .data_out(dout[0]),
        .out_valid(vld[0]), .overflow(ovf[0]), .evt_count(cnt[0]));

    multi_mode_bus_sync #(.N(8), .SYNC_STAGES(2), .MODE(1), .CNT_W(8)) u_rise (
        .clk(clk), .rst_n(rst_n), .ena(ena), .stb(stb), .data_in(data_in),
        .out_ready(out_ready), .ovf_clr(ovf_clr), .data_out(dout[1]),
        .out_valid(vld[1]), .overflow(ovf[1]), .evt_count(cnt[1]));

    multi_mode_bus_sync #(.N(8), .SYNC_STAGES(3), .MODE(2), .CNT_W(8)) u_tog (
        .clk(clk), .rst_n(rst_n), .ena(ena), .stb(stb), .data_in(data_in),
        .out_ready(out_ready), .ovf_clr(ovf_clr), .data_out(dout[2]),
        .out_valid(vld[2]), .overflow(ovf[2]), .evt_count(cnt[2]));

    function automatic int stages_of(input int m);
        return (m == 2) ? 3 : 2;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 3; m++) begin
            m_d[m] = 8'h00; m_v[m] = 1'b0; m_o[m] = 1'b0; m_c[m] = 8'h00;
            m_hist[m] = 16'h0000; m_prev[m] = 1'b0;
        end
    endtask

    task automatic push_expected();
        snap_t e;
        for (int m = 0; m < 3; m++) begin
            e[m].d = m_d[m]; e[m].v = m_v[m]; e[m].o = m_o[m]; e[m].c = m_c[m];
        end
        exp_q.push_back(e);
    endtask

    // m_hist[k] is the strobe sampled k+1 enabled edges ago
    task automatic model_edge();
        logic s, evt, free;
        if (!rst_n) begin
            model_clear();
        end else if (ena) begin
            for (int m = 0; m < 3; m++) begin
                s = m_hist[m][stages_of(m)-1];
                if (m == 0)      evt = s;
                else if (m == 1) evt = s && !m_prev[m];
                else             evt = (s != m_prev[m]);
                free = !m_v[m] || out_ready;
                if (evt && free) begin
                    m_d[m] = data_in;
                    m_v[m] = 1'b1;
                    m_c[m] = m_c[m] + 8'd1;
                end else if (!evt && m_v[m] && out_ready) begin
                    m_v[m] = 1'b0;
                end
                if (evt && !free)  m_o[m] = 1'b1;
                else if (ovf_clr)  m_o[m] = 1'b0;
                m_hist[m] = {m_hist[m][14:0], stb};
                m_prev[m] = s;
            end
        end
        push_expected();
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        model_clear();
        push_expected();
        -> ev_now;
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(negedge clk or ev_now);
            if (done) begin
                vectors++;
                if (exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int m = 0; m < 3; m++) begin
                    vectors++;
                    if (dout[m] !== e[m].d || vld[m] !== e[m].v ||
                        ovf[m] !== e[m].o || cnt[m] !== e[m].c) begin
                        miscompares++;
                        $display("FAIL mode%0d_state t=%0t: got d=%h v=%b o=%b c=%h, expected d=%h v=%b o=%b c=%h",
                                 m, $time, dout[m], vld[m], ovf[m], cnt[m],
                                 e[m].d, e[m].v, e[m].o, e[m].c);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected summary");
        $fatal(1);
    end

    initial begin : driver
        model_clear();
        cycle(2);
        rst_n = 1'b1;
        cycle(3);

        // latency / first capture with 0xA5, downstream stalled
        data_in = 8'hA5; out_ready = 1'b0; stb = 1'b1;
        cycle(5);

        // second strobe while stalled drops 0x3C, then clear overflow
        stb = 1'b0; cycle(3);
        data_in = 8'h3C; stb = 1'b1; cycle(4);
        ovf_clr = 1'b1; cycle(1);
        ovf_clr = 1'b0; cycle(2);

        // consume and capture together
        out_ready = 1'b1; data_in = 8'h22; stb = 1'b0; cycle(5);
        data_in = 8'h11; stb = 1'b1; cycle(5);

        // level-mode streaming long enough to wrap the counter
        stb = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 270; i++) begin
            data_in = i[7:0];
            cycle(1);
        end

        // ena gating in the middle of synchronisation
        stb = 1'b0; out_ready = 1'b0; cycle(4);
        out_ready = 1'b1; cycle(2);
        out_ready = 1'b0; data_in = 8'h5A; stb = 1'b1; cycle(1);
        ena = 1'b0; out_ready = 1'b1; cycle(5);
        ena = 1'b1; out_ready = 1'b0; cycle(6);

        // build valid+overflow, then reset mid-operation with strobe held high
        stb = 1'b0; cycle(3);
        data_in = 8'hC3; stb = 1'b1; cycle(4);
        reset_now();
        cycle(2);
        rst_n = 1'b1;
        cycle(6);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0) stb = ~stb;
            data_in   = 8'($urandom);
            out_ready = ($urandom_range(2) != 0);
            ena       = ($urandom_range(7) != 0);
            ovf_clr   = ($urandom_range(7) == 0);
            cycle(1);
        end

        ena = 1'b1; ovf_clr = 1'b0;
        cycle(2);
        done = 1'b1;
        -> ev_now;
    end

endmodule
